// File: rtl/piso_scan_pkg.sv
// Shared definitions for the dual-chain PISO scan scheduler: FSM states,
// chain geometry, Bear/Ship field positions and small decode helpers.
package piso_scan_pkg;

    localparam int unsigned NCHAIN = 2;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned BIT_W  = 4;

    // Bear is a contiguous slice of Frame0
    localparam int unsigned BEAR_LSB = 1;
    localparam int unsigned BEAR_W   = 12;

    // Ship is assembled bit-reversed from Frame0[13..15] then Frame1[0..4]
    localparam int unsigned SHIP_W      = 8;
    localparam int unsigned SHIP_F0_LSB = 13;
    localparam int unsigned SHIP_F0_N   = 3;
    localparam int unsigned SHIP_F1_LSB = 0;
    localparam int unsigned SHIP_F1_N   = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_SHIFT,
        ST_STORE,
        ST_GAP
    } state_t;

    function automatic logic [BEAR_W-1:0] bear_of(input logic [WORD_W-1:0] f0);
        return f0[BEAR_LSB +: BEAR_W];
    endfunction

    function automatic logic [SHIP_W-1:0] ship_of(input logic [WORD_W-1:0] f0,
                                                  input logic [WORD_W-1:0] f1);
        logic [SHIP_W-1:0] s;
        s = '0;
        for (int unsigned i = 0; i < SHIP_F0_N; i++)
            s[SHIP_W-1-i] = f0[SHIP_F0_LSB+i];
        for (int unsigned i = 0; i < SHIP_F1_N; i++)
            s[SHIP_F1_N-1-i] = f1[SHIP_F1_LSB+i];
        return s;
    endfunction

    // Line levels {shift clock, SH/LD} for the selected chain in a given state
    function automatic logic [1:0] lines_of(input state_t st, input logic hi);
        logic [1:0] l;
        l = 2'b01;
        case (st)
            ST_LOAD:   l = 2'b00;
            ST_SETTLE: l = 2'b01;
            ST_SHIFT:  l = {hi, 1'b1};
            default:   l = 2'b01;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/piso_tick_gen.sv
// Half-period divider: pulses tick_o on every DIV-th cycle; restart_i holds
// the count at zero so the next timed FSM state starts on a clean boundary.
module piso_tick_gen #(
    parameter int unsigned DIV = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam int unsigned CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear on restart or wrap, otherwise advance
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (restart_i || (cnt_q == LAST))
            cnt_d = '0;
    end

    // Count register
    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/piso_scan_sched.sv
// Dual-chain PISO scan scheduler: one timing engine scans chain 0 then
// chain 1, publishes both words together with a one-cycle FrameVld, and
// optionally re-scans every GAP cycles. Optional feature macro:
// PISO_SCAN_DEBOUNCE_EN (publish only when two consecutive raw pairs agree).
module piso_scan_sched
    import piso_scan_pkg::*;
#(
    parameter int unsigned DIV = 16,
    parameter int unsigned GAP = 1024
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Start,
    input  logic                AutoEn,
    input  logic [NCHAIN-1:0]   PdiDat,
    output logic [NCHAIN-1:0]   PdiClk,
    output logic [NCHAIN-1:0]   PdiLt,
    output logic [WORD_W-1:0]   Frame0,
    output logic [WORD_W-1:0]   Frame1,
    output logic [BEAR_W-1:0]   Bear,
    output logic [SHIP_W-1:0]   Ship,
    output logic                FrameVld,
    output logic                Busy
);

    localparam logic [15:0] GAP_N = 16'(GAP);

    state_t              state_q, state_d;
    logic                sel_q, sel_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic                hi_q, hi_d;
    logic [WORD_W-1:0]   sr_q, sr_d;
    logic [WORD_W-1:0]   raw0_q, raw0_d;
    logic [WORD_W-1:0]   frame0_q, frame0_d;
    logic [WORD_W-1:0]   frame1_q, frame1_d;
    logic                vld_q, vld_d;
    logic                pend_q, pend_d;
    logic [15:0]         gap_q, gap_d;
    logic [NCHAIN-1:0]   clk_q, clk_d;
    logic [NCHAIN-1:0]   lt_q, lt_d;
`ifdef PISO_SCAN_DEBOUNCE_EN
    logic [WORD_W-1:0]   prev0_q, prev0_d;
    logic [WORD_W-1:0]   prev1_q, prev1_d;
`endif

    logic restart;
    logic tick;
    logic gap_expired;

    piso_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk_i     (Clk),
        .rst_i     (Reset),
        .restart_i (restart),
        .tick_o    (tick)
    );

    assign gap_expired = (gap_q == GAP_N);

    // Next-state, datapath and registered line levels for the scan engine
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        bit_d    = bit_q;
        hi_d     = hi_q;
        sr_d     = sr_q;
        raw0_d   = raw0_q;
        frame0_d = frame0_q;
        frame1_d = frame1_q;
        vld_d    = 1'b0;
        pend_d   = pend_q;
        gap_d    = gap_expired ? gap_q : gap_q + 16'd1;
        restart  = 1'b0;
`ifdef PISO_SCAN_DEBOUNCE_EN
        prev0_d  = prev0_q;
        prev1_d  = prev1_q;
`endif

        case (state_q)
            ST_IDLE: begin
                restart = 1'b1;
                // Start, a held request and an auto expiry all fold into one launch
                if (Start || pend_q || (AutoEn && gap_expired)) begin
                    state_d = ST_LOAD;
                    sel_d   = 1'b0;
                    pend_d  = 1'b0;
                end
            end
            ST_LOAD: begin
                if (tick)
                    state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (tick) begin
                    state_d = ST_SHIFT;
                    bit_d   = '0;
                    hi_d    = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (hi_q) begin
                        hi_d  = 1'b0;
                        bit_d = bit_q + BIT_W'(1);
                    end else begin
                        sr_d = {sr_q[WORD_W-2:0], PdiDat[sel_q]};
                        // The last bit has no trailing high half: 15 rising edges per chain
                        if (bit_q == BIT_W'(WORD_W - 1))
                            state_d = ST_STORE;
                        else
                            hi_d = 1'b1;
                    end
                end
            end
            ST_STORE: begin
                restart = 1'b1;
                if (!sel_q) begin
                    raw0_d  = sr_q;
                    sel_d   = 1'b1;
                    state_d = ST_LOAD;
                end else begin
`ifdef PISO_SCAN_DEBOUNCE_EN
                    prev0_d = raw0_q;
                    prev1_d = sr_q;
                    if ((raw0_q == prev0_q) && (sr_q == prev1_q)) begin
                        frame0_d = raw0_q;
                        frame1_d = sr_q;
                        vld_d    = 1'b1;
                    end
`else
                    frame0_d = raw0_q;
                    frame1_d = sr_q;
                    vld_d    = 1'b1;
`endif
                    gap_d   = 16'd1;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                restart = 1'b1;
                sel_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (Start && (state_q != ST_IDLE))
            pend_d = 1'b1;

        // Outputs are registered from the next state so the chain lines never glitch
        clk_d = '0;
        lt_d  = '1;
        {clk_d[sel_d], lt_d[sel_d]} = lines_of(state_d, hi_d);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            sel_q    <= 1'b0;
            bit_q    <= '0;
            hi_q     <= 1'b0;
            sr_q     <= '0;
            raw0_q   <= '0;
            frame0_q <= '0;
            frame1_q <= '0;
            vld_q    <= 1'b0;
            pend_q   <= 1'b0;
            gap_q    <= '0;
            clk_q    <= '0;
            lt_q     <= '1;
`ifdef PISO_SCAN_DEBOUNCE_EN
            prev0_q  <= '0;
            prev1_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            bit_q    <= bit_d;
            hi_q     <= hi_d;
            sr_q     <= sr_d;
            raw0_q   <= raw0_d;
            frame0_q <= frame0_d;
            frame1_q <= frame1_d;
            vld_q    <= vld_d;
            pend_q   <= pend_d;
            gap_q    <= gap_d;
            clk_q    <= clk_d;
            lt_q     <= lt_d;
`ifdef PISO_SCAN_DEBOUNCE_EN
            prev0_q  <= prev0_d;
            prev1_q  <= prev1_d;
`endif
        end
    end

    assign PdiClk   = clk_q;
    assign PdiLt    = lt_q;
    assign Frame0   = frame0_q;
    assign Frame1   = frame1_q;
    assign Bear     = bear_of(frame0_q);
    assign Ship     = ship_of(frame0_q, frame1_q);
    assign FrameVld = vld_q;
    assign Busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_piso_scan_sched.sv
// Bench for piso_scan_sched: two behavioural 74HC165-style chain models feed
// the DUT; expected frames, fields, timing and line activity come from the
// chain words and the published timing rules.
module tb_piso_scan_sched;

    localparam int DIV      = 2;
    localparam int GAPC     = 10;
    localparam int CHAIN    = 33 * DIV;
    localparam int SCAN_LAT = 66 * DIV + 2;
    localparam int PERIOD   = SCAN_LAT + GAPC;
`ifdef PISO_SCAN_DEBOUNCE_EN
    localparam bit DEBOUNCE = 1'b1;
`else
    localparam bit DEBOUNCE = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        AutoEn = 1'b0;
    logic [1:0]  PdiDat;
    logic [1:0]  PdiClk;
    logic [1:0]  PdiLt;
    logic [15:0] Frame0;
    logic [15:0] Frame1;
    logic [11:0] Bear;
    logic [7:0]  Ship;
    logic        FrameVld;
    logic        Busy;

    int n_vec = 0;
    int n_err = 0;

    // Chain models and reference state
    logic [15:0] word0 = 16'h0000;
    logic [15:0] word1 = 16'h0000;
    logic [15:0] sh0 = 16'h0000;
    logic [15:0] sh1 = 16'h0000;
    logic [1:0]  pclk_m = 2'b00;
    logic [15:0] prev0_m = 16'h0000;
    logic [15:0] prev1_m = 16'h0000;
    logic [15:0] exp_f0 = 16'h0000;
    logic [15:0] exp_f1 = 16'h0000;

    piso_scan_sched #(
        .DIV (DIV),
        .GAP (GAPC)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .AutoEn   (AutoEn),
        .PdiDat   (PdiDat),
        .PdiClk   (PdiClk),
        .PdiLt    (PdiLt),
        .Frame0   (Frame0),
        .Frame1   (Frame1),
        .Bear     (Bear),
        .Ship     (Ship),
        .FrameVld (FrameVld),
        .Busy     (Busy)
    );

    always #5 Clk = ~Clk;

    // Shift registers: parallel load while SH/LD low, shift MSB-out on a rising shift clock
    always @(negedge Clk) begin
        if (!PdiLt[0]) sh0 <= word0;
        else if (PdiClk[0] && !pclk_m[0]) sh0 <= {sh0[14:0], 1'b0};
        if (!PdiLt[1]) sh1 <= word1;
        else if (PdiClk[1] && !pclk_m[1]) sh1 <= {sh1[14:0], 1'b0};
        pclk_m <= PdiClk;
    end
    assign PdiDat = {sh1[15], sh0[15]};

    function automatic logic [11:0] bear_ref(input logic [15:0] f0);
        return 12'((f0 >> 1) & 16'h0FFF);
    endfunction

    function automatic logic [7:0] ship_ref(input logic [15:0] f0, input logic [15:0] f1);
        return {f0[13], f0[14], f0[15], f1[0], f1[1], f1[2], f1[3], f1[4]};
    endfunction

    // One Start-triggered scan with full line monitoring and result checks
    task automatic do_scan(input logic [15:0] w0, input logic [15:0] w1, input string tag);
        int cyc, rise0, rise1, low0, low1, xviol, vld_at, nvld;
        logic [1:0] pp;
        logic pub, busy0, busy_lat, busy_aft;
        logic [15:0] f0_lat, f1_lat;
        logic [11:0] b_lat;
        logic [7:0] s_lat;
        pub = !DEBOUNCE || ((w0 == prev0_m) && (w1 == prev1_m));
        word0 = w0;
        word1 = w1;
        @(negedge Clk); Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
        cyc = 0; rise0 = 0; rise1 = 0; low0 = 0; low1 = 0; xviol = 0;
        vld_at = -1; nvld = 0; pp = 2'b00; busy0 = Busy; busy_lat = 1'b0; busy_aft = 1'b1;
        f0_lat = '0; f1_lat = '0; b_lat = '0; s_lat = '0;
        while (cyc <= SCAN_LAT + 3) begin
            if (PdiClk[0] && !pp[0]) rise0++;
            if (PdiClk[1] && !pp[1]) rise1++;
            if (!PdiLt[0]) low0++;
            if (!PdiLt[1]) low1++;
            if (cyc <= CHAIN) begin
                if (PdiClk[1] !== 1'b0 || PdiLt[1] !== 1'b1) xviol++;
            end else begin
                if (PdiClk[0] !== 1'b0 || PdiLt[0] !== 1'b1) xviol++;
            end
            if (FrameVld === 1'b1) begin
                nvld++;
                if (vld_at < 0) vld_at = cyc;
            end
            if (cyc == SCAN_LAT) begin
                busy_lat = Busy; f0_lat = Frame0; f1_lat = Frame1; b_lat = Bear; s_lat = Ship;
            end
            if (cyc == SCAN_LAT + 1) busy_aft = Busy;
            pp = PdiClk;
            @(negedge Clk); cyc++;
        end
        if (pub) begin
            exp_f0 = w0;
            exp_f1 = w1;
            n_vec++; if (vld_at != SCAN_LAT) begin n_err++; $display("FAIL %s latency: got %0d want %0d", tag, vld_at, SCAN_LAT); end
            n_vec++; if (f0_lat !== w0) begin n_err++; $display("FAIL %s Frame0: got %h want %h", tag, f0_lat, w0); end
            n_vec++; if (f1_lat !== w1) begin n_err++; $display("FAIL %s Frame1: got %h want %h", tag, f1_lat, w1); end
            n_vec++; if (b_lat !== bear_ref(w0)) begin n_err++; $display("FAIL %s Bear: got %h want %h", tag, b_lat, bear_ref(w0)); end
            n_vec++; if (s_lat !== ship_ref(w0, w1)) begin n_err++; $display("FAIL %s Ship: got %b want %b", tag, s_lat, ship_ref(w0, w1)); end
        end else begin
            n_vec++; if (Frame0 !== exp_f0 || Frame1 !== exp_f1) begin n_err++; $display("FAIL %s held frames: got %h/%h want %h/%h", tag, Frame0, Frame1, exp_f0, exp_f1); end
        end
        n_vec++; if (nvld != (pub ? 1 : 0)) begin n_err++; $display("FAIL %s FrameVld count: got %0d want %0d", tag, nvld, pub ? 1 : 0); end
        n_vec++; if (rise0 != 15 || rise1 != 15) begin n_err++; $display("FAIL %s clock edges: got %0d/%0d want 15/15", tag, rise0, rise1); end
        n_vec++; if (low0 != DIV || low1 != DIV) begin n_err++; $display("FAIL %s load width: got %0d/%0d want %0d", tag, low0, low1, DIV); end
        n_vec++; if (xviol != 0) begin n_err++; $display("FAIL %s idle-chain activity: got %0d want 0", tag, xviol); end
        n_vec++; if (busy0 !== 1'b1 || busy_lat !== 1'b1 || busy_aft !== 1'b0) begin n_err++; $display("FAIL %s Busy window: got %b%b%b want 110", tag, busy0, busy_lat, busy_aft); end
        prev0_m = w0;
        prev1_m = w1;
    endtask

    task automatic test_reset();
        n_vec++; if (PdiClk !== 2'b00) begin n_err++; $display("FAIL reset PdiClk: got %b want 00", PdiClk); end
        n_vec++; if (PdiLt !== 2'b11) begin n_err++; $display("FAIL reset PdiLt: got %b want 11", PdiLt); end
        n_vec++; if (Frame0 !== 16'h0 || Frame1 !== 16'h0) begin n_err++; $display("FAIL reset frames: got %h/%h want 0/0", Frame0, Frame1); end
        n_vec++; if (Bear !== 12'h0 || Ship !== 8'h0) begin n_err++; $display("FAIL reset fields: got %h/%h want 0/0", Bear, Ship); end
        n_vec++; if (FrameVld !== 1'b0 || Busy !== 1'b0) begin n_err++; $display("FAIL reset strobes: got %b%b want 00", FrameVld, Busy); end
    endtask

    task automatic test_directed();
        do_scan(16'hA5C3, 16'h001F, "directed");
        if (!DEBOUNCE) begin
            n_vec++; if (Bear !== 12'h2E1 || Ship !== 8'b10111111) begin n_err++; $display("FAIL directed fields: got %h/%b want 2e1/10111111", Bear, Ship); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 4)) @(negedge Clk);
            do_scan(16'($urandom), 16'($urandom), "random");
        end
    endtask

    // Three Starts while busy collapse into one follow-on scan
    task automatic test_back_to_back();
        int cyc;
        int t[$];
        word0 = prev0_m;
        word1 = prev1_m;
        @(negedge Clk); Start = 1'b1;
        @(negedge Clk);
        cyc = 0;
        while (cyc < 420) begin
            Start = (cyc == 10 || cyc == 50 || cyc == 100);
            if (FrameVld === 1'b1) t.push_back(cyc);
            @(negedge Clk); cyc++;
        end
        Start = 1'b0;
        n_vec++; if (t.size() != 2) begin n_err++; $display("FAIL pending scan count: got %0d want 2", t.size()); end
        n_vec++; if (t.size() > 1 && (t[0] != SCAN_LAT || t[1] != 2 * SCAN_LAT + 2)) begin n_err++; $display("FAIL pending timing: got %0d/%0d want %0d/%0d", t[0], t[1], SCAN_LAT, 2 * SCAN_LAT + 2); end
        n_vec++; if (Busy !== 1'b0 || Frame0 !== prev0_m) begin n_err++; $display("FAIL pending end: got busy %b frame %h want 0 %h", Busy, Frame0, prev0_m); end
    endtask

    // Periodic scanning, Start coinciding with an expiry, and AutoEn dropped mid-scan
    task automatic test_auto();
        int cyc;
        int t[$];
        word0 = prev0_m;
        word1 = prev1_m;
        @(negedge Clk); AutoEn = 1'b1;
        cyc = 0;
        while (cyc < 1100) begin
            @(negedge Clk); cyc++;
            if (FrameVld === 1'b1) t.push_back(cyc);
            Start = (t.size() == 1 && cyc == t[0] + GAPC - 1);
            if (t.size() == 4 && cyc == t[3] + 20) AutoEn = 1'b0;
        end
        Start = 1'b0;
        AutoEn = 1'b0;
        n_vec++; if (t.size() != 5) begin n_err++; $display("FAIL auto pulse count: got %0d want 5", t.size()); end
        for (int i = 1; i < t.size(); i++) begin
            n_vec++; if (t[i] - t[i-1] != PERIOD) begin n_err++; $display("FAIL auto period %0d: got %0d want %0d", i, t[i] - t[i-1], PERIOD); end
        end
        n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL auto stop: got busy %b want 0", Busy); end
    endtask

    task automatic test_reset_mid();
        int bad;
        do_scan(16'hBEEF, 16'h0F0F, "pre-reset");
        do_scan(16'hBEEF, 16'h0F0F, "pre-reset");
        n_vec++; if (Frame0 !== 16'hBEEF) begin n_err++; $display("FAIL pre-reset Frame0: got %h want beef", Frame0); end
        @(negedge Clk); Start = 1'b1;
        @(negedge Clk); Start = 1'b0;
        repeat (40) @(negedge Clk);
        n_vec++; if (Busy !== 1'b1) begin n_err++; $display("FAIL mid-scan Busy: got %b want 1", Busy); end
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        test_reset();
        prev0_m = '0; prev1_m = '0; exp_f0 = '0; exp_f1 = '0;
        bad = 0;
        repeat (300) begin
            @(negedge Clk);
            if (FrameVld !== 1'b0 || Busy !== 1'b0) bad++;
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL post-reset activity: got %0d want 0", bad); end
    endtask

    task automatic test_debounce();
        do_scan(16'h1234, 16'h4321, "deb-1234a");
        do_scan(16'h1234, 16'h4321, "deb-1234b");
        do_scan(16'h5678, 16'h8765, "deb-5678a");
        do_scan(16'h5678, 16'h8765, "deb-5678b");
        n_vec++; if (Frame0 !== 16'h5678 || Frame1 !== 16'h8765) begin n_err++; $display("FAIL debounce final: got %h/%h want 5678/8765", Frame0, Frame1); end
    endtask

    initial begin
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_auto();
        test_reset_mid();
        test_debounce();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
